// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel button debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

   // Per-channel debounce FSM states.
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      HELD        = 2'd2,
      ARM_RELEASE = 2'd3
   } deb_state_t;

   localparam int MAX_NCH = 32;

   // Counter width for a count range of n cycles; never narrower than 1 bit.
   function automatic int deb_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int deb_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchronizer, stability FSM, optional auto-repeat.
// Latency: raw edge to level change is STABLE_CYCLES+2 cycles; pulses coincide with the level change.
// Backpressure: none; all outputs are free-running levels/one-cycle pulses.
//
// Ports: clk, rst (sync, active-high), button (raw async level),
//        level (debounced, 1 = pressed), press_pulse, release_pulse, repeat_pulse.
// Optional feature: DEBOUNCER_REPEAT_EN enables the auto-repeat counter;
// otherwise repeat_pulse is tied low and no repeat logic exists.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int PRESSED_VALUE = 1,
   parameter int STABLE_CYCLES = 250000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int             CW       = deb_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

   // Polarity is folded in ahead of the flops so that the reset value of the
   // synchronizer (0) always reads as "released", whatever the pressed level.
   // This is a constant inversion and adds no timing to the path.
   logic btn_norm;
   logic sync_q1;
   logic sync_q2;

   assign btn_norm = (PRESSED_VALUE != 0) ? button : ~button;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn_norm;
         sync_q2 <= sync_q1;
      end
   end

   logic pressed;
   assign pressed = sync_q2;

   deb_state_t     state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           press_nxt;
   logic           release_nxt;
   logic           level_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         level         <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   // The counter only advances while arming; every transition leaves it at 0.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = '0;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) state_nxt = ARM_PRESS;
         end
         ARM_PRESS: begin
            if (!pressed) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = HELD;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!pressed) state_nxt = ARM_RELEASE;
         end
         ARM_RELEASE: begin
            if (pressed) begin
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      level_nxt = (state_nxt == HELD) || (state_nxt == ARM_RELEASE);
   end

`ifdef DEBOUNCER_REPEAT_EN
   localparam int             RW        = deb_cnt_width(deb_max(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0]  DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  PER_LAST  = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_first;
   logic          rep_stay;
   logic          rep_hit;

   // Count only on cycles that start and end in a held state: the press edge
   // itself restarts the count, and the release edge clears it, so a repeat
   // never coincides with a press or release pulse.
   assign rep_stay = ((state == HELD) || (state == ARM_RELEASE)) && level_nxt;
   assign rep_hit  = rep_first ? (rep_cnt == DLY_LAST) : (rep_cnt == PER_LAST);

   always_ff @(posedge clk) begin
      if (rst || !rep_stay) begin
         rep_cnt      <= '0;
         rep_first    <= 1'b1;
         repeat_pulse <= 1'b0;
      end else if (rep_hit) begin
         rep_cnt      <= '0;
         rep_first    <= 1'b0;
         repeat_pulse <= 1'b1;
      end else begin
         rep_cnt      <= rep_cnt + 1'b1;
         repeat_pulse <= 1'b0;
      end
   end
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
   assign repeat_pulse   = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// NCH independent button debouncers with press/release/auto-repeat pulses.
// Latency: raw edge to o_level change (and its pulse) is STABLE_CYCLES+2 cycles.
// Backpressure: none; outputs are levels and one-cycle pulses.
//
// Ports: clk, rst (sync, active-high), i_button[NCH] raw levels,
//        o_level[NCH] debounced state, o_press/o_release/o_repeat[NCH] pulses.
// Optional feature: define DEBOUNCER_REPEAT_EN for auto-repeat; without it
// o_repeat is all zeros and the port list is the same.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int NCH           = 4,
   parameter int PRESSED_VALUE = 1,
   parameter int STABLE_CYCLES = 250000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] i_button,
   output logic [NCH-1:0] o_level,
   output logic [NCH-1:0] o_press,
   output logic [NCH-1:0] o_release,
   output logic [NCH-1:0] o_repeat
);

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      debounce_channel #(
         .PRESSED_VALUE (PRESSED_VALUE),
         .STABLE_CYCLES (STABLE_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .button        (i_button[ch]),
         .level         (o_level[ch]),
         .press_pulse   (o_press[ch]),
         .release_pulse (o_release[ch]),
         .repeat_pulse  (o_repeat[ch])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: two instances (active-high and active-low press).
// Cycle k is the k-th rising edge after stimulus for that edge is applied; outputs are sampled 1 time unit after it.
// Expected vectors are hand-derived from the stated latency/repeat timing.
module tb_multi_debouncer;

   localparam int NCH = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] btn   = '0;
   logic [NCH-1:0] btn_n = '1;
   logic [NCH-1:0] level, press, rel, rpt;
   logic [NCH-1:0] level_n, press_n, rel_n, rpt_n;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multi_debouncer #(
      .NCH(NCH), .PRESSED_VALUE(1), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk), .rst(rst), .i_button(btn),
      .o_level(level), .o_press(press), .o_release(rel), .o_repeat(rpt)
   );

   multi_debouncer #(
      .NCH(NCH), .PRESSED_VALUE(0), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_n (
      .clk(clk), .rst(rst), .i_button(btn_n),
      .o_level(level_n), .o_press(press_n), .o_release(rel_n), .o_repeat(rpt_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected repeat bit for a channel accepted at cycle 6 whose level is high until cycle hi (exclusive).
   function automatic logic rep_exp(input int k, input int hi);
`ifdef DEBOUNCER_REPEAT_EN
      return (k >= 16) && (k < hi) && (((k - 16) % 3) == 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset(input string name);
      btn   = '0;
      btn_n = '1;
      rst   = 1'b1;
      repeat (3) step();
      check({name, " rst level"},   32'(level),   32'h0);
      check({name, " rst press"},   32'(press),   32'h0);
      check({name, " rst release"}, 32'(rel),     32'h0);
      check({name, " rst repeat"},  32'(rpt),     32'h0);
      check({name, " rst level_n"}, 32'(level_n), 32'h0);
      rst = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      logic [NCH-1:0] e_lvl, e_prs, e_rel, e_rpt;

      // Clean press on ch0, held long enough to see the repeat train.
      do_reset("A");
      for (int k = 0; k <= 30; k++) begin
         if (k == 0) btn[0] = 1'b1;
         step();
         e_lvl = {1'b0, k >= 6};
         e_prs = {1'b0, k == 6};
         e_rpt = {1'b0, rep_exp(k, 1000)};
         check($sformatf("A level c%0d", k),   32'(level), 32'(e_lvl));
         check($sformatf("A press c%0d", k),   32'(press), 32'(e_prs));
         check($sformatf("A release c%0d", k), 32'(rel),   32'h0);
         check($sformatf("A repeat c%0d", k),  32'(rpt),   32'(e_rpt));
      end

      // 3-cycle glitch on ch1 must be rejected.
      do_reset("B");
      for (int k = 0; k <= 14; k++) begin
         if (k == 0) btn[1] = 1'b1;
         if (k == 3) btn[1] = 1'b0;
         step();
         check($sformatf("B level c%0d", k),   32'(level), 32'h0);
         check($sformatf("B press c%0d", k),   32'(press), 32'h0);
         check($sformatf("B release c%0d", k), 32'(rel),   32'h0);
      end

      // Simultaneous press on both channels, ch0 released at cycle 20.
      do_reset("C");
      for (int k = 0; k <= 30; k++) begin
         if (k == 0)  btn = 2'b11;
         if (k == 20) btn[0] = 1'b0;
         step();
         e_lvl = {k >= 6, (k >= 6) && (k < 26)};
         e_prs = (k == 6) ? 2'b11 : 2'b00;
         e_rel = (k == 26) ? 2'b01 : 2'b00;
         e_rpt = {rep_exp(k, 1000), rep_exp(k, 26)};
         check($sformatf("C level c%0d", k),   32'(level), 32'(e_lvl));
         check($sformatf("C press c%0d", k),   32'(press), 32'(e_prs));
         check($sformatf("C release c%0d", k), 32'(rel),   32'(e_rel));
         check($sformatf("C repeat c%0d", k),  32'(rpt),   32'(e_rpt));
      end

      // Reset during hold: no release, re-accepted 6 cycles after rst drops.
      do_reset("D");
      for (int k = 0; k <= 20; k++) begin
         if (k == 0)  btn[0] = 1'b1;
         if (k == 8)  rst = 1'b1;
         if (k == 10) rst = 1'b0;
         step();
         e_lvl = {1'b0, ((k >= 6) && (k < 8)) || (k >= 16)};
         e_prs = {1'b0, (k == 6) || (k == 16)};
         check($sformatf("D level c%0d", k),   32'(level), 32'(e_lvl));
         check($sformatf("D press c%0d", k),   32'(press), 32'(e_prs));
         check($sformatf("D release c%0d", k), 32'(rel),   32'h0);
         check($sformatf("D repeat c%0d", k),  32'(rpt),   32'h0);
      end

      // Active-low instance: same timing as the clean press.
      do_reset("E");
      for (int k = 0; k <= 12; k++) begin
         if (k == 0) btn_n[0] = 1'b0;
         step();
         e_lvl = {1'b0, k >= 6};
         e_prs = {1'b0, k == 6};
         check($sformatf("E level_n c%0d", k),   32'(level_n), 32'(e_lvl));
         check($sformatf("E press_n c%0d", k),   32'(press_n), 32'(e_prs));
         check($sformatf("E release_n c%0d", k), 32'(rel_n),   32'h0);
         check($sformatf("E repeat_n c%0d", k),  32'(rpt_n),   32'h0);
      end
      // Active-low release of ch0 at cycle 13 -> release pulse at cycle 19.
      for (int k = 13; k <= 21; k++) begin
         if (k == 13) btn_n[0] = 1'b1;
         step();
         check($sformatf("E level_n c%0d", k),   32'(level_n), 32'({1'b0, k < 19}));
         check($sformatf("E release_n c%0d", k), 32'(rel_n),   32'({1'b0, k == 19}));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent button channels (1..32).
REQ-002 The block SHALL have parameter PRESSED_VALUE, default 1, giving the raw input level that means "pressed".
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 250000, giving the consecutive cycles a new level must hold before acceptance (minimum 2).
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the cycles from press acceptance to the first repeat pulse (minimum 2).
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 5000000, giving the cycles between later repeat pulses (minimum 2).
REQ-006 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port i_button, input, NCH bits, the raw asynchronous button levels.
REQ-009 The block SHALL have port o_level, output, NCH bits, the debounced state per channel (1 = pressed).
REQ-010 The block SHALL have port o_press, output, NCH bits, a one-cycle pulse when a press is accepted.
REQ-011 The block SHALL have port o_release, output, NCH bits, a one-cycle pulse when a release is accepted.
REQ-012 The block SHALL have port o_repeat, output, NCH bits, a one-cycle auto-repeat pulse while a button is held.

Function
REQ-013 Each i_button bit SHALL pass through a 2-flop synchronizer, then be normalised so that 1 = pressed regardless of PRESSED_VALUE.
REQ-014 Each channel SHALL run an FSM with the states IDLE, ARM_PRESS, HELD and ARM_RELEASE.
REQ-015 FSM transitions: IDLE->ARM_PRESS on synced press; ARM_PRESS->IDLE on synced release; ARM_PRESS->HELD when the counter reaches STABLE_CYCLES-1 with press still synced; HELD->ARM_RELEASE on synced release; ARM_RELEASE->HELD on synced press; ARM_RELEASE->IDLE when the counter reaches STABLE_CYCLES-1 with release still synced.
REQ-016 The stability counter SHALL be $clog2(STABLE_CYCLES) bits, increment each cycle in ARM_*, and clear on any transition, so that a glitch shorter than STABLE_CYCLES produces no output.
REQ-017 o_level SHALL be 1 in HELD and ARM_RELEASE and 0 in IDLE and ARM_PRESS, registered.
REQ-018 o_press SHALL assert for exactly one cycle, on the same edge that o_level rises; o_release SHALL assert for exactly one cycle, on the same edge that o_level falls.
REQ-019 Latency from a clean raw edge to the o_level change SHALL be exactly STABLE_CYCLES+2 cycles.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous, per-channel correct pulses.
REQ-021 o_press, o_release and o_repeat SHALL never be high together on one channel.

Reset
REQ-022 While rst=1, every FSM SHALL be in IDLE, all counters and synchronizer flops SHALL be 0, and o_level, o_press, o_release and o_repeat SHALL be all zeros.
REQ-023 A reset asserted mid-count or mid-hold SHALL abort the count or hold without emitting o_release.
REQ-024 A button held through reset SHALL be re-accepted STABLE_CYCLES+2 cycles after rst deasserts.

Configuration
REQ-025 The macro DEBOUNCER_REPEAT_EN SHALL control the auto-repeat feature.
REQ-026 With DEBOUNCER_REPEAT_EN defined, each channel SHALL have a repeat counter that clears on o_press, pulses o_repeat REPEAT_DELAY cycles after o_press, then pulses every REPEAT_PERIOD cycles while in HELD or ARM_RELEASE, and clears on leaving them.
REQ-027 Without DEBOUNCER_REPEAT_EN, o_repeat SHALL be tied to zeros, no repeat counters SHALL be synthesised, and the port list SHALL be unchanged.

Structure
REQ-028 The package debounce_pkg SHALL hold the FSM state enum type and the counter-width helper constants.
REQ-029 The sub-module debounce_channel (one synchronizer, FSM and counter set) SHALL be instantiated NCH times by a generate loop.

Verification
Benches use NCH=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-030 Clean press on ch0 at cycle 0 -> o_level[0] and o_press[0] rise at cycle 6; o_press[0] is high for 1 cycle.
REQ-031 A 3-cycle glitch on ch1 -> o_level, o_press and o_release stay 0.
REQ-032 Press ch0 and ch1 on the same cycle, release ch0 at cycle 20 -> both o_press at cycle 6; o_release[0] only, at cycle 26.
REQ-033 Hold ch0 with repeat enabled -> o_repeat[0] at cycles 16, 19, 22 and so on; with the macro off, o_repeat stays 0.
REQ-034 Assert rst at cycle 8 while held -> all outputs 0, no o_release; after rst drops at cycle 10 with the button still pressed, o_press is seen at cycle 16.
REQ-035 PRESSED_VALUE=0 with an active-low press -> same timing as REQ-030.
